// File: rtl/gpu_pipe_pkg.sv
// Types and constants shared by the GPU pixel pipeline blocks.
package gpu_pipe_pkg;

    localparam int unsigned RGB_W   = 24;
    localparam int unsigned COORD_W = 11;

    typedef logic [RGB_W-1:0]   rgb888_t;
    typedef logic [COORD_W-1:0] screen_coord_t;

    localparam rgb888_t PIXEL_TRANSPARENT_BLACK = 24'h000000;

endpackage

// File: rtl/pixel_output_fifo_if.sv
// Palette-stage push side and HDMI pop side of the pixel output FIFO.
interface pixel_output_fifo_if
    import gpu_pipe_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
);

    logic            inValid;
    logic            pixelFound;
    rgb888_t         pipeReadData;
    screen_coord_t   xPosition;
    screen_coord_t   yPosition;
    logic            pixelReq;
    rgb888_t         outData;
    logic            outValid;
    logic            pipeStall;
    logic            fifoEmpty;
    logic            fifoFull;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            underflow;

    modport master (
        output inValid, pixelFound, pipeReadData, xPosition, yPosition, pixelReq,
        input  outData, outValid, pipeStall, fifoEmpty, fifoFull, count, overflow, underflow
    );

    modport slave (
        input  inValid, pixelFound, pipeReadData, xPosition, yPosition, pixelReq,
        output outData, outValid, pipeStall, fifoEmpty, fifoFull, count, overflow, underflow
    );

endinterface

// File: rtl/pixel_fifo_mem.sv
// DEPTH x 24 pixel storage: synchronous write, asynchronous read.
module pixel_fifo_mem
    import gpu_pipe_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  rgb888_t           wdata,
    input  logic [ADDR_W-1:0] raddr,
    output rgb888_t           rdata
);

    rgb888_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_output_fifo.sv
// Pixel output FIFO: drops transparent and repeated-coordinate results,
// buffers the first opaque layer per position, pops one pixel per request.
module pixel_output_fifo
    import gpu_pipe_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic clk_pipe,
    input  logic rst,
    pixel_output_fifo_if.slave bus
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_next;
    logic              last_valid;
    screen_coord_t     last_x;
    screen_coord_t     last_y;
    rgb888_t           out_data;
    logic              out_valid;
    logic              pipe_stall;
    logic              overflow_q;
    logic              underflow_q;
    rgb888_t           rd_data;

    logic repeat_hit;
    logic qual_push;
    logic pop_ok;
    logic push_ok;
    logic is_empty;
    logic is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));

    // Push/pop qualification; a pop frees a slot so a full FIFO can still accept.
    always_comb begin
        repeat_hit = last_valid && (bus.xPosition == last_x) && (bus.yPosition == last_y);
        qual_push  = bus.inValid && bus.pixelFound && !repeat_hit;
        pop_ok     = bus.pixelReq && !is_empty;
        push_ok    = qual_push && (!is_full || pop_ok);
        count_next = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    pixel_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk_pipe),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (bus.pipeReadData),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk_pipe or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            last_valid  <= 1'b0;
            last_x      <= '0;
            last_y      <= '0;
            out_data    <= PIXEL_TRANSPARENT_BLACK;
            out_valid   <= 1'b0;
            pipe_stall  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q    <= count_next;
            pipe_stall <= (count_next >= CNT_W'(DEPTH - 2));
            if (qual_push) begin
                last_valid <= 1'b1;
                last_x     <= bus.xPosition;
                last_y     <= bus.yPosition;
                if (!push_ok) overflow_q <= 1'b1;
            end
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (bus.pixelReq) begin
                out_valid <= pop_ok;
                out_data  <= pop_ok ? rd_data : PIXEL_TRANSPARENT_BLACK;
                if (pop_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
                else        underflow_q <= 1'b1;
            end
        end
    end

    assign bus.outData   = out_data;
    assign bus.outValid  = out_valid;
    assign bus.pipeStall = pipe_stall;
    assign bus.fifoEmpty = is_empty;
    assign bus.fifoFull  = is_full;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_pixel_output_fifo.sv
// Scoreboard bench for pixel_output_fifo with DEPTH=16.
module tb_pixel_output_fifo;
    import gpu_pipe_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic clk_pipe = 1'b0;
    logic rst      = 1'b0;

    pixel_output_fifo_if #(.DEPTH(DEPTH)) bus ();

    pixel_output_fifo #(.DEPTH(DEPTH)) dut (
        .clk_pipe (clk_pipe),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk_pipe = ~clk_pipe;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    rgb888_t       exp_q[$];
    logic          m_lv;
    screen_coord_t m_lx, m_ly;
    rgb888_t       m_out;
    logic          m_outv, m_over, m_under, m_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_lv = 0; m_lx = '0; m_ly = '0;
        m_out = PIXEL_TRANSPARENT_BLACK; m_outv = 0;
        m_over = 0; m_under = 0; m_stall = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},     32'(bus.count),     32'(exp_q.size()));
        check({tag, ".empty"},     32'(bus.fifoEmpty), 32'(exp_q.size() == 0));
        check({tag, ".full"},      32'(bus.fifoFull),  32'(exp_q.size() == DEPTH));
        check({tag, ".outData"},   32'(bus.outData),   32'(m_out));
        check({tag, ".outValid"},  32'(bus.outValid),  32'(m_outv));
        check({tag, ".stall"},     32'(bus.pipeStall), 32'(m_stall));
        check({tag, ".overflow"},  32'(bus.overflow),  32'(m_over));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(m_under));
    endtask

    // One clock: drive inputs, update model, check #1 after the edge.
    task automatic cycle(input string tag, input logic v, input logic f, input rgb888_t d,
                         input int x, input int y, input logic req);
        logic qual, popped, stored;
        bus.inValid = v; bus.pixelFound = f; bus.pipeReadData = d;
        bus.xPosition = screen_coord_t'(x); bus.yPosition = screen_coord_t'(y);
        bus.pixelReq = req;
        qual   = v && f && !(m_lv && screen_coord_t'(x) == m_lx && screen_coord_t'(y) == m_ly);
        popped = req && (exp_q.size() > 0);
        stored = qual && ((exp_q.size() < DEPTH) || popped);
        if (req) begin
            if (popped) begin m_out = exp_q.pop_front(); m_outv = 1; end
            else begin m_out = '0; m_outv = 0; m_under = 1; end
        end
        if (qual) begin
            m_lv = 1; m_lx = screen_coord_t'(x); m_ly = screen_coord_t'(y);
            if (stored) exp_q.push_back(d);
            else m_over = 1;
        end
        m_stall = (exp_q.size() >= DEPTH - 2);
        @(posedge clk_pipe);
        #1;
        check_all(tag);
        bus.inValid = 0; bus.pixelFound = 0; bus.pixelReq = 0;
    endtask

    initial begin
        bus.inValid = 0; bus.pixelFound = 0; bus.pipeReadData = '0;
        bus.xPosition = '0; bus.yPosition = '0; bus.pixelReq = 0;
        model_reset();
        #12 rst = 1'b1;
        #1 check_all("reset");

        // Underflow on empty, then push+pop on empty (no bypass)
        cycle("uf_pop", 0, 0, 24'h0, 0, 0, 1);
        cycle("uf_pushpop", 1, 1, 24'h123456, 1, 1, 1);
        cycle("uf_drain", 0, 0, 24'h0, 0, 0, 1);

        // Dedupe and transparency
        cycle("dd_a", 1, 1, 24'hFF0000, 3, 7, 0);
        cycle("dd_rep", 1, 1, 24'h00FF00, 3, 7, 0);
        cycle("dd_transp", 1, 0, 24'h000000, 3, 7, 0);
        cycle("dd_b", 1, 1, 24'h0000FF, 4, 7, 0);
        check("dd_count2", 32'(bus.count), 32'd2);
        cycle("dd_pop1", 0, 0, 24'h0, 0, 0, 1);
        check("dd_first", 32'(bus.outData), 32'hFF0000);
        cycle("dd_pop2", 0, 0, 24'h0, 0, 0, 1);
        check("dd_second", 32'(bus.outData), 32'h0000FF);
        cycle("dd_idle", 0, 0, 24'h0, 0, 0, 0);

        // Fill, stall, overflow, push+pop while full
        for (int i = 0; i < 17; i++) begin
            cycle("full_push", 1, 1, 24'(32'h100000 + i), 100 + i, 20, 0);
            if (i == 13) check("stall_after14", 32'(bus.pipeStall), 32'd1);
        end
        check("full_flag", 32'(bus.fifoFull), 32'd1);
        check("full_over", 32'(bus.overflow), 32'd1);
        check("full_count", 32'(bus.count), 32'd16);
        cycle("full_pushpop", 1, 1, 24'hABCDEF, 200, 20, 1);
        check("full_pp_count", 32'(bus.count), 32'd16);
        for (int i = 0; i < DEPTH; i++) cycle("full_drain", 0, 0, 24'h0, 0, 0, 1);

        // Pop latency: push at N, request at N+1, data visible in N+2
        cycle("lat_push", 1, 1, 24'hA1B2C3, 500, 1, 0);
        cycle("lat_pop", 0, 0, 24'h0, 0, 0, 1);
        check("lat_data", 32'(bus.outData), 32'hA1B2C3);
        check("lat_valid", 32'(bus.outValid), 32'd1);
        cycle("lat_hold", 0, 0, 24'h0, 0, 0, 0);

        // Continuous push+pop across pointer wrap
        for (int i = 0; i < 40; i++)
            cycle("wrap", 1, 1, 24'(32'h000100 + i), 600 + i, 3, 1);
        cycle("wrap_last", 0, 0, 24'h0, 0, 0, 1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++)
            cycle("rs_fill", 1, 1, 24'(32'h00AA00 + i), 700 + i, 4, 0);
        check("rs_precount", 32'(bus.count), 32'd5);
        #3 rst = 1'b0;
        #1;
        model_reset();
        check("rs_count", 32'(bus.count), 32'd0);
        check("rs_empty", 32'(bus.fifoEmpty), 32'd1);
        check("rs_outData", 32'(bus.outData), 32'd0);
        check("rs_over", 32'(bus.overflow), 32'd0);
        check("rs_under", 32'(bus.underflow), 32'd0);
        #2 rst = 1'b1;
        cycle("rs_after", 0, 0, 24'h0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
